// File: rtl/pipelined_ripple_adder_if.sv
// Valid/ready bundle for pipelined_ripple_adder.
// The ovf wire exists only when ADDER_OVF_FLAG_EN is defined.
interface pipelined_ripple_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_OVF_FLAG_EN
    logic             ovf;
`endif

`ifdef ADDER_OVF_FLAG_EN
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/pipelined_ripple_adder.sv
// WIDTH-bit adder resolved SEG_W bits per pipeline stage, carry registered between stages.
// Optional signed-overflow flag: define ADDER_OVF_FLAG_EN.
module pipelined_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    pipelined_ripple_adder_if.slave  bus
);
    localparam int STAGES = WIDTH / SEG_W;
    localparam int MSB    = WIDTH - 1;
    // Operand carry registers are only needed ahead of the last stage.
    localparam int AB_N   = (STAGES > 1) ? STAGES - 1 : 1;

    if (WIDTH < 1 || SEG_W < 1 || (WIDTH % SEG_W) != 0) begin : g_bad_cfg
        $error("pipelined_ripple_adder: SEG_W must divide WIDTH");
    end

    logic             adv_s;

    logic             vld_r   [STAGES];
    logic             carry_r [STAGES];
    logic [WIDTH-1:0] res_r   [STAGES];
    logic [WIDTH-1:0] a_r     [AB_N];
    logic [WIDTH-1:0] b_r     [AB_N];

    logic             vld_in_s [STAGES];
    logic             c_in_s   [STAGES];
    logic [WIDTH-1:0] res_in_s [STAGES];
    logic [WIDTH-1:0] a_in_s   [STAGES];
    logic [WIDTH-1:0] b_in_s   [STAGES];
    logic [SEG_W:0]   seg_s    [STAGES];
    logic [WIDTH-1:0] res_nxt_s[STAGES];

    // Stage 0 is fed from the ports; every later stage from its predecessor's registers.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage_in
        if (k == 0) begin : g_head
            assign vld_in_s[k] = bus.in_valid;
            assign c_in_s[k]   = bus.cin;
            assign res_in_s[k] = {WIDTH{1'b0}};
            assign a_in_s[k]   = bus.a;
            assign b_in_s[k]   = bus.b;
        end else begin : g_body
            assign vld_in_s[k] = vld_r[k-1];
            assign c_in_s[k]   = carry_r[k-1];
            assign res_in_s[k] = res_r[k-1];
            assign a_in_s[k]   = a_r[k-1];
            assign b_in_s[k]   = b_r[k-1];
        end
    end

    // Combinational ripple over each stage's segment, merged into the resolved sum bits.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            seg_s[k] = {1'b0, a_in_s[k][k*SEG_W +: SEG_W]}
                     + {1'b0, b_in_s[k][k*SEG_W +: SEG_W]}
                     + {{SEG_W{1'b0}}, c_in_s[k]};
            res_nxt_s[k] = res_in_s[k];
            res_nxt_s[k][k*SEG_W +: SEG_W] = seg_s[k][SEG_W-1:0];
        end
    end

    // The whole pipe advances together or freezes together; empty stages are not squeezed out.
    assign adv_s = !vld_r[STAGES-1] || bus.out_ready;

    // Stage registers: cleared on reset, shifted on advance, held on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_r[k]   <= 1'b0;
                carry_r[k] <= 1'b0;
                res_r[k]   <= {WIDTH{1'b0}};
            end
            for (int k = 0; k < AB_N; k++) begin
                a_r[k] <= {WIDTH{1'b0}};
                b_r[k] <= {WIDTH{1'b0}};
            end
        end else if (adv_s) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_r[k]   <= vld_in_s[k];
                carry_r[k] <= seg_s[k][SEG_W];
                res_r[k]   <= res_nxt_s[k];
            end
            for (int k = 0; k < AB_N; k++) begin
                a_r[k] <= a_in_s[k];
                b_r[k] <= b_in_s[k];
            end
        end
    end

    assign bus.in_ready  = adv_s;
    assign bus.out_valid = vld_r[STAGES-1];
    assign bus.sum       = res_r[STAGES-1];
    assign bus.cout      = carry_r[STAGES-1];

`ifdef ADDER_OVF_FLAG_EN
    logic am_r    [STAGES];
    logic bm_r    [STAGES];
    logic am_in_s [STAGES];
    logic bm_in_s [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_msb_in
        if (k == 0) begin : g_head
            assign am_in_s[k] = bus.a[MSB];
            assign bm_in_s[k] = bus.b[MSB];
        end else begin : g_body
            assign am_in_s[k] = am_r[k-1];
            assign bm_in_s[k] = bm_r[k-1];
        end
    end

    // Operand sign bits travel alongside the data so ovf lines up with sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                am_r[k] <= 1'b0;
                bm_r[k] <= 1'b0;
            end
        end else if (adv_s) begin
            for (int k = 0; k < STAGES; k++) begin
                am_r[k] <= am_in_s[k];
                bm_r[k] <= bm_in_s[k];
            end
        end
    end

    assign bus.ovf = (am_r[STAGES-1] == bm_r[STAGES-1])
                  && (res_r[STAGES-1][MSB] != am_r[STAGES-1]);
`endif
endmodule
